// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states and
// the default bus-timeout settings.
package riscv_lsu_pkg;

  localparam logic [2:0] LSU_SIZE_B  = 3'd0;
  localparam logic [2:0] LSU_SIZE_H  = 3'd1;
  localparam logic [2:0] LSU_SIZE_W  = 3'd2;
  localparam logic [2:0] LSU_SIZE_BU = 3'd4;
  localparam logic [2:0] LSU_SIZE_HU = 3'd5;

  localparam int unsigned LSU_TIMEOUT_CYCLES = 255;
  localparam int unsigned LSU_CNT_W          = 8;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering for the LSU: byte enables and replicated write data
// for stores, lane extraction plus sign/zero extension for loads.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wd_i,
  input  logic [31:0] rd_i,
  output logic [3:0]  be_o,
  output logic [31:0] wd_o,
  output logic [31:0] rd_o
);

  logic [31:0] lane;

  // Shift the addressed lane down to bit 0, then steer/extend by size.
  always_comb begin
    be_o = 4'b0000;
    wd_o = 32'h0;
    rd_o = 32'h0;
    lane = rd_i >> {offset_i, 3'b000};
    case (size_i)
      LSU_SIZE_B: begin
        be_o = 4'b0001 << offset_i;
        wd_o = {4{wd_i[7:0]}};
        rd_o = {{24{lane[7]}}, lane[7:0]};
      end
      LSU_SIZE_BU: begin
        be_o = 4'b0001 << offset_i;
        wd_o = {4{wd_i[7:0]}};
        rd_o = {24'h0, lane[7:0]};
      end
      LSU_SIZE_H: begin
        be_o = 4'b0011 << offset_i;
        wd_o = {2{wd_i[15:0]}};
        rd_o = {{16{lane[15]}}, lane[15:0]};
      end
      LSU_SIZE_HU: begin
        be_o = 4'b0011 << offset_i;
        wd_o = {2{wd_i[15:0]}};
        rd_o = {16'h0, lane[15:0]};
      end
      LSU_SIZE_W: begin
        be_o = 4'b1111;
        wd_o = wd_i;
        rd_o = lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit between execute stage and data memory.
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
// Bus handshake: data_req_o is raised in REQ and, together with all data_*
// outputs, held stable until the cycle data_gnt_i is seen high; the
// response (data_rvalid_i) is accepted only in WAIT, so stray gnt/rvalid
// pulses in any other state have no effect.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = LSU_CNT_W
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_misalign_o,
  output logic        core_err_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wd_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rd_i,
  output lsu_state_e  dbg_state_o
);

  if (TIMEOUT_CYCLES >= (2 ** CNT_W)) begin : g_bad_cfg
    $error("riscv_lsu: TIMEOUT_CYCLES does not fit in CNT_W bits");
  end

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wd_q, wd_d, rd_q, rd_d;
  logic        size_illegal, misaligned, bus_req;
  logic [3:0]  al_be;
  logic [31:0] al_wd, al_rd;

`ifdef LSU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d, to_hit;
  assign to_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  // Classify the incoming request; illegal size outranks misalignment.
  always_comb begin
    size_illegal = 1'b1;
    misaligned   = 1'b0;
    case (core_size_i)
      LSU_SIZE_B:  size_illegal = 1'b0;
      LSU_SIZE_H:  begin size_illegal = 1'b0;      misaligned = core_addr_i[0];    end
      LSU_SIZE_W:  begin size_illegal = 1'b0;      misaligned = |core_addr_i[1:0]; end
      LSU_SIZE_BU: size_illegal = core_we_i;
      LSU_SIZE_HU: begin size_illegal = core_we_i; misaligned = core_addr_i[0];    end
      default: ;
    endcase
  end

  riscv_lsu_align u_align (
    .size_i   (size_q),
    .offset_i (addr_q[1:0]),
    .wd_i     (wd_q),
    .rd_i     (data_rd_i),
    .be_o     (al_be),
    .wd_o     (al_wd),
    .rd_o     (al_rd)
  );

  // Next-state and core-side outputs of the transaction FSM.
  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    size_d          = size_q;
    addr_d          = addr_q;
    wd_d            = wd_q;
    rd_d            = rd_q;
    bus_req         = 1'b0;
    core_stall_o    = 1'b0;
    core_misalign_o = 1'b0;
    core_err_o      = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d           = cnt_q;
    to_d            = to_q;
`endif
    case (state_q)
      LSU_IDLE: begin
        if (core_req_i) begin
          if (size_illegal) begin
            core_err_o = 1'b1;
          end else if (misaligned) begin
            core_misalign_o = 1'b1;
          end else begin
            core_stall_o = 1'b1;
            we_d         = core_we_i;
            size_d       = core_size_i;
            addr_d       = core_addr_i;
            wd_d         = core_wd_i;
            state_d      = LSU_REQ;
`ifdef LSU_TIMEOUT_EN
            cnt_d        = '0;
            to_d         = 1'b0;
`endif
          end
        end
      end
      LSU_REQ: begin
        bus_req      = 1'b1;
        core_stall_o = 1'b1;
        if (data_gnt_i) state_d = LSU_WAIT;
`ifdef LSU_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
        if (to_hit) begin
          state_d = LSU_DONE;
          rd_d    = 32'h0;
          to_d    = 1'b1;
        end
`endif
      end
      LSU_WAIT: begin
        core_stall_o = 1'b1;
        if (data_rvalid_i) begin
          rd_d    = we_q ? 32'h0 : al_rd;
          state_d = LSU_DONE;
        end
`ifdef LSU_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
        if (to_hit && !data_rvalid_i) begin
          state_d = LSU_DONE;
          rd_d    = 32'h0;
          to_d    = 1'b1;
        end
`endif
      end
      LSU_DONE: begin
        state_d = LSU_IDLE;
`ifdef LSU_TIMEOUT_EN
        core_err_o = to_q;
`endif
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      size_q  <= 3'd0;
      addr_q  <= 32'h0;
      wd_q    <= 32'h0;
      rd_q    <= 32'h0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  // Bus outputs are only non-zero while a request is being presented.
  assign data_req_o  = bus_req;
  assign data_we_o   = bus_req & we_q;
  assign data_be_o   = bus_req ? al_be : 4'b0000;
  assign data_addr_o = bus_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign data_wd_o   = bus_req ? al_wd : 32'h0;
  assign core_rd_o   = rd_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu (timeout test active with LSU_TIMEOUT_EN).
module tb_riscv_lsu;
  import riscv_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        core_req_i, core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i, core_wd_i, core_rd_o;
  logic        core_stall_o, core_misalign_o, core_err_o;
  logic        data_req_o, data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o, data_wd_o;
  logic        data_gnt_i, data_rvalid_i;
  logic [31:0] data_rd_i;
  lsu_state_e  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // Clock and DUT.
  always #5 clk = ~clk;

  riscv_lsu #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
    .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
    .core_stall_o(core_stall_o), .core_misalign_o(core_misalign_o), .core_err_o(core_err_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wd_o(data_wd_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_rd_i(data_rd_i), .dbg_state_o(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk);    endtask

  // Reference model: access width in bytes, 0 for an unknown code.
  function automatic int nbytes(input logic [2:0] s);
    case (s)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  // 0 = accepted, 1 = misaligned, 2 = illegal.
  function automatic int classify(input logic [2:0] s, input logic we, input logic [31:0] a);
    int nb = nbytes(s);
    if (nb == 0 || (s >= 3'd4 && we)) return 2;
    if ((a % nb) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
    int nb = nbytes(s);
    int off = int'(a % 4);
    int v = ((1 << nb) - 1) << off;
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] wd);
    logic [31:0] r;
    int nb = nbytes(s);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] s, input logic we,
                                       input logic [31:0] a, input logic [31:0] rdata);
    int nb = nbytes(s);
    int bits = 8 * nb;
    longint v;
    if (we) return 32'h0;
    v = (longint'(rdata) >> (8 * (a % 4))) & ((64'd1 << bits) - 1);
    if (s < 3'd4 && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
    return v[31:0];
  endfunction

  // Drive one access with the given grant and response delays and check
  // every cycle of it against the model.
  task automatic access(input logic [2:0] s, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdata,
                        input int gd, input int rdl, input string tag);
    int k;
    logic [31:0] e_rd;
    k = classify(s, we, a);
    tick();
    core_req_i = 1'b1; core_we_i = we; core_size_i = s;
    core_addr_i = a; core_wd_i = wd; data_rd_i = rdata;
    mid();
    chk({tag, " idle_stall"}, core_stall_o, k == 0);
    chk({tag, " misalign"}, core_misalign_o, k == 1);
    chk({tag, " err"}, core_err_o, k == 2);
    chk({tag, " idle_req"}, data_req_o, 1'b0);
    if (k != 0) begin
      tick();
      core_req_i = 1'b0;
      mid();
      chk({tag, " after_reject_req"}, data_req_o, 1'b0);
      chk({tag, " after_reject_flags"}, {core_misalign_o, core_err_o, core_stall_o}, 3'b000);
      chk({tag, " after_reject_state"}, 32'(dbg_state), 32'(LSU_IDLE));
      return;
    end
    exp_q.push_back(m_rd(s, we, a, rdata));
    for (int c = 0; c <= gd; c++) begin
      tick();
      data_gnt_i = (c == gd);
      mid();
      chk({tag, " req"}, {data_req_o, core_stall_o, data_we_o}, {2'b11, we});
      chk({tag, " addr"}, data_addr_o, a & 32'hFFFF_FFFC);
      chk({tag, " be"}, data_be_o, m_be(s, a));
      chk({tag, " wd"}, data_wd_o, m_wd(s, wd));
    end
    tick();
    data_gnt_i = 1'b0;
    for (int c = 0; c <= rdl; c++) begin
      data_rvalid_i = (c == rdl);
      mid();
      chk({tag, " wait"}, {data_req_o, core_stall_o}, 2'b01);
      tick();
    end
    data_rvalid_i = 1'b0;
    data_gnt_i = 1'($urandom_range(0, 1));
    e_rd = exp_q.pop_front();
    mid();
    chk({tag, " done_stall"}, {core_stall_o, data_req_o, core_err_o}, 3'b000);
    chk({tag, " done_rd"}, core_rd_o, e_rd);
    tick();
    core_req_i = 1'b0;
    mid();
    chk({tag, " idle_after"}, {data_req_o, core_stall_o}, 2'b00);
    chk({tag, " rd_held"}, core_rd_o, e_rd);
    data_gnt_i = 1'b0;
  endtask

  initial begin
    logic [2:0]  s;
    logic [31:0] a;
    int gmax;
    rst_i = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
    core_addr_i = 32'h0; core_wd_i = 32'h0; data_gnt_i = 1'b0;
    data_rvalid_i = 1'b0; data_rd_i = 32'h0;
    repeat (2) @(posedge clk);
    mid();
    chk("reset_bus", {data_req_o, data_we_o, data_be_o}, 6'b0);
    chk("reset_addr", data_addr_o, 32'h0);
    chk("reset_wd", data_wd_o, 32'h0);
    chk("reset_core", {core_stall_o, core_misalign_o, core_err_o}, 3'b000);
    chk("reset_rd", core_rd_o, 32'h0);
    chk("reset_state", 32'(dbg_state), 32'(LSU_IDLE));
    tick();
    rst_i = 1'b0;

    // Directed cases.
    access(LSU_SIZE_B,  1'b0, 32'h103, 32'h0,        32'h80AABBCC, 0, 0, "t1_lb");
    access(LSU_SIZE_H,  1'b1, 32'h202, 32'h1234ABCD, 32'h5555AAAA, 2, 0, "t2_sh");
    access(LSU_SIZE_W,  1'b0, 32'h301, 32'h0,        32'h0,        0, 0, "t3_lw_mis");
    access(LSU_SIZE_HU, 1'b0, 32'h7,   32'h0,        32'h0,        0, 0, "t3_lhu_mis");
    access(3'd4,        1'b1, 32'h10,  32'hFF,       32'h0,        0, 0, "t4_bu_store");
    access(3'd7,        1'b0, 32'h3,   32'h0,        32'h0,        0, 0, "t4_sz7_prio");
    access(3'd3,        1'b0, 32'h0,   32'h0,        32'h0,        0, 0, "t4_sz3");
    access(LSU_SIZE_HU, 1'b0, 32'h2,   32'h0,        32'h8001FFFF, 1, 1, "t4_lhu");
    access(LSU_SIZE_W,  1'b1, 32'h44,  32'hDEADBEEF, 32'h0,        0, 1, "t4_sw");
    access(LSU_SIZE_H,  1'b0, 32'h12,  32'h0,        32'h9ABC1234, 0, 0, "t4_lh");

    // Reset while a request is being presented.
    tick();
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = LSU_SIZE_W; core_addr_i = 32'h40;
    mid();
    tick();
    core_req_i = 1'b0;
    mid();
    chk("t5_req_before_rst", data_req_o, 1'b1);
    #1 rst_i = 1'b1;
    #1;
    chk("t5_req_async_drop", data_req_o, 1'b0);
    chk("t5_state_rst", 32'(dbg_state), 32'(LSU_IDLE));
    chk("t5_rd_rst", core_rd_o, 32'h0);
    tick();
    rst_i = 1'b0;

    // Reset while waiting for the response, then a stale response.
    core_req_i = 1'b1; data_rd_i = 32'h12345678;
    mid();
    tick();
    data_gnt_i = 1'b1;
    mid();
    tick();
    data_gnt_i = 1'b0; core_req_i = 1'b0;
    mid();
    chk("t5_in_wait", {data_req_o, core_stall_o}, 2'b01);
    #1 rst_i = 1'b1;
    #1;
    chk("t5_wait_rst_state", 32'(dbg_state), 32'(LSU_IDLE));
    tick();
    rst_i = 1'b0;
    data_rvalid_i = 1'b1;
    mid();
    chk("t5_stale_rvalid", {data_req_o, core_stall_o}, 2'b00);
    chk("t5_stale_rd", core_rd_o, 32'h0);
    tick();
    data_rvalid_i = 1'b0;
    mid();
    chk("t5_stale_state", 32'(dbg_state), 32'(LSU_IDLE));
    chk("t5_stale_rd2", core_rd_o, 32'h0);

`ifdef LSU_TIMEOUT_EN
    access(LSU_SIZE_B, 1'b0, 32'h1, 32'h0, 32'h00007F00, 0, 0, "t6_pre");
    tick();
    core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = LSU_SIZE_W; core_addr_i = 32'h80;
    mid();
    chk("t6_idle_stall", core_stall_o, 1'b1);
    for (int c = 0; c < 4; c++) begin
      tick();
      mid();
      chk("t6_req_cycle", {data_req_o, core_stall_o}, 2'b11);
    end
    tick();
    mid();
    chk("t6_done_err", core_err_o, 1'b1);
    chk("t6_done_rd", core_rd_o, 32'h0);
    chk("t6_done_bus", {data_req_o, core_stall_o}, 2'b00);
    tick();
    core_req_i = 1'b0;
    mid();
    chk("t6_idle_state", 32'(dbg_state), 32'(LSU_IDLE));
    chk("t6_idle_err", core_err_o, 1'b0);
    gmax = 1;
`else
    access(LSU_SIZE_W, 1'b0, 32'h84, 32'h0, 32'hCAFEF00D, 12, 5, "t6_no_timeout");
    gmax = 3;
`endif

    // Randomized accesses against the model.
    for (int i = 0; i < 80; i++) begin
      s = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      access(s, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
             $urandom_range(0, gmax), $urandom_range(0, gmax), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load/store unit that responds to the core decoder's memory-control outputs (mem_req, mem_we, mem_size) and drives the data-memory bus.
- Stores: generates byte enables and lane-replicated write data.
- Loads: extracts and sign/zero-extends read data.
- Stalls the core while a bus transaction is outstanding.
- Sits between the execute stage (ALU address, rs2 data) and the data memory.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles in REQ+WAIT before a bus error (used only with LSU_TIMEOUT_EN).
- CNT_W, 8, timeout counter width; TIMEOUT_CYCLES must be < 2**CNT_W.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- core_req_i  in  1  memory access requested (decoder mem_req)
- core_we_i  in  1  1 = store (decoder mem_we)
- core_size_i  in  3  size code: 0 B, 1 H, 2 W, 4 BU, 5 HU (decoder mem_size)
- core_addr_i  in  32  byte address from ALU
- core_wd_i  in  32  store data (rs2)
- core_rd_o  out  32  extended load data, valid in DONE
- core_stall_o  out  1  core must hold its current instruction
- core_misalign_o  out  1  misaligned access, no bus request issued
- core_err_o  out  1  illegal size code or bus timeout
- data_req_o  out  1  bus request
- data_we_o  out  1  bus write
- data_be_o  out  4  byte enables
- data_addr_o  out  32  word address, bits [1:0] forced to 0
- data_wd_o  out  32  lane-replicated write data
- data_gnt_i  in  1  request accepted
- data_rvalid_i  in  1  response/ack, at least 1 cycle after gnt
- data_rd_i  in  32  read word

Behaviour:
- Reset: state IDLE; all outputs 0; captured request registers 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, core_req_i=1, legal and aligned:
  - Capture we, size, addr, wd.
  - core_stall_o=1 combinationally.
  - Next state REQ.
- IDLE, core_req_i=1, misaligned (H/HU with addr[0]=1; W with addr[1:0]≠0):
  - core_misalign_o=1 for that cycle, stall 0, no bus activity, stay IDLE.
- IDLE, core_req_i=1, illegal size (3, 6, 7, or 4/5 with core_we_i=1):
  - core_err_o=1 for that cycle, stall 0, stay IDLE.
  - Illegal size takes priority over misaligned.
- REQ:
  - data_req_o=1; data_* driven from captured registers; stall=1.
  - data_gnt_i=1 → WAIT; otherwise stay in REQ with all data_* held stable.
- WAIT:
  - data_req_o=0; stall=1.
  - data_rvalid_i=1 → register extended load data (0 for stores) → DONE.
- DONE:
  - stall=0; core_rd_o valid for exactly this cycle; core_req_i ignored.
  - Next state IDLE.
- core_rd_o is held at its last value outside DONE.
- Minimum latency: 3 stall cycles (gnt in first REQ cycle, rvalid the next cycle).
- Byte-lane rules, o = captured addr[1:0]:
  - B: be = 4'b0001<<o; wd = {4{wd[7:0]}}
  - H: be = 4'b0011<<o; wd = {2{wd[15:0]}}
  - W: be = 4'b1111; wd = wd
- Load extract: lane = data_rd_i >> (8*o).
  - B and H sign-extend bit 7 / bit 15.
  - BU and HU zero-extend.
- Spurious data_gnt_i or data_rvalid_i in IDLE/DONE (e.g. after a reset mid-op) is ignored.
- Reset mid-op: immediate return to IDLE, data_req_o drops asynchronously.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined:
  - Counter clears on entry to REQ and increments each REQ/WAIT cycle.
  - When the count reaches TIMEOUT_CYCLES: drop data_req_o, go to DONE with core_err_o=1 and core_rd_o=0 for that cycle.
- Undefined:
  - No counter; REQ/WAIT wait indefinitely.
  - core_err_o is asserted only for an illegal size.

Decomposition:
- riscv_lsu_pkg holds:
  - size constants LSU_SIZE_B=3'd0, LSU_SIZE_H=3'd1, LSU_SIZE_W=3'd2, LSU_SIZE_BU=3'd4, LSU_SIZE_HU=3'd5
  - the FSM state enum
  - the default TIMEOUT_CYCLES constant
- One combinational sub-module, riscv_lsu_align:
  - inputs: size, offset, store data, read data
  - outputs: byte enables, replicated write data, extended load data
  - instantiated once in riscv_lsu.

Test Plan:
1. LB at addr 0x103, data_rd_i=0x80AABBCC, gnt in REQ, rvalid next cycle → data_addr_o=0x100, be=4'b1000; core_rd_o=0xFFFFFF80 in DONE; stall high for exactly 3 cycles.
2. SH at 0x202, wd=0x1234ABCD, gnt delayed 2 cycles → data_req_o held 3 cycles with be=4'b1100, wd=0xABCDABCD, we=1; rvalid → DONE, stall drops.
3. LW at 0x301 → core_misalign_o=1 for one cycle, stall=0, data_req_o never asserted; same for LHU at 0x7.
4. Size code 4 with core_we_i=1 → core_err_o=1 for one cycle, no bus request; LHU at 0x2 with data_rd_i=0x8001FFFF → core_rd_o=0x00008001.
5. rst_i asserted while in WAIT, then rvalid pulses → data_req_o=0 immediately, FSM in IDLE, core_rd_o=0, stale rvalid ignored.
6. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4: gnt never asserted → after 4 REQ cycles, DONE with core_err_o=1, core_rd_o=0, data_req_o=0; then IDLE.
